// File: rtl/adventure_rooms_pkg.sv
// Shared room encodings and button-direction indices for the adventure game.
package adv_pkg;

    typedef enum logic [2:0] {
        CAVE   = 3'd0,
        TUNNEL = 3'd1,
        RIVER  = 3'd2,
        STASH  = 3'd3,
        DEN    = 3'd4,
        VAULT  = 3'd5,
        GRAVE  = 3'd6
    } room_t;

    localparam int DIR_N = 0;
    localparam int DIR_S = 1;
    localparam int DIR_E = 2;
    localparam int DIR_W = 3;

    localparam int NUM_ROOMS = 7;

endpackage

// File: rtl/adventure_rooms_btn_edge.sv
// Turns the four direction buttons into single-cycle press pulses and
// flags when exactly one direction was pressed on this edge.
module btn_edge (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn,
    output logic [3:0] press,
    output logic       one_hot
);

    logic [3:0] r_prev;
    logic [3:0] w_low;

    // History starts at all-ones so a button held through reset release is
    // not mistaken for a fresh press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prev <= 4'b1111;
        end else begin
            r_prev <= btn;
        end
    end

    // Rising-edge detect and a clear-lowest-bit test for "exactly one set".
    always_comb begin
        press   = btn & ~r_prev;
        w_low   = press & (press - 4'd1);
        one_hot = (press != 4'd0) && (w_low == 4'd0);
    end

endmodule

// File: rtl/adventure_rooms.sv
// Room-navigation FSM: one room move per accepted press, Dragon's Den
// resolution against the sword flag, room LEDs and a saturating move count.
module adventure_rooms
    import adv_pkg::*;
#(
    parameter int MOVE_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_n,
    input  logic              btn_s,
    input  logic              btn_e,
    input  logic              btn_w,
    input  logic              v,
    output logic              sw,
    output logic [6:0]        room,
    output logic [2:0]        room_id,
    output logic              win,
    output logic              die,
    output logic [MOVE_W-1:0] moves
);

    room_t             r_state;
    room_t             w_next;
    logic [MOVE_W-1:0] r_moves;
    logic [3:0]        w_btn;
    logic [3:0]        w_press;
    logic              w_one_hot;
    logic              w_move;

    assign w_btn = {btn_w, btn_e, btn_s, btn_n};

    btn_edge u_btn_edge (
        .clk     (clk),
        .reset   (reset),
        .btn     (w_btn),
        .press   (w_press),
        .one_hot (w_one_hot)
    );

    // State register; reset drops the player back in the cave.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= CAVE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next room from the single accepted press; the Den resolves on its own
    // and the terminal rooms ignore buttons until reset.
    always_comb begin
        w_next = r_state;
        w_move = 1'b0;
        case (r_state)
            CAVE: begin
                if (w_one_hot && w_press[DIR_E]) w_next = TUNNEL;
            end
            TUNNEL: begin
                if (w_one_hot && w_press[DIR_S]) w_next = RIVER;
                if (w_one_hot && w_press[DIR_W]) w_next = CAVE;
            end
            RIVER: begin
                if (w_one_hot && w_press[DIR_W]) w_next = TUNNEL;
                if (w_one_hot && w_press[DIR_N]) w_next = STASH;
                if (w_one_hot && w_press[DIR_E]) w_next = DEN;
            end
            STASH: begin
                if (w_one_hot && w_press[DIR_E]) w_next = RIVER;
            end
            DEN: begin
                w_next = v ? VAULT : GRAVE;
            end
            VAULT: w_next = VAULT;
            GRAVE: w_next = GRAVE;
            default: w_next = CAVE;
        endcase
        if ((r_state != DEN) && (w_next != r_state) &&
            (r_state == CAVE || r_state == TUNNEL ||
             r_state == RIVER || r_state == STASH)) begin
            w_move = 1'b1;
        end
    end

    // Count only player moves that changed the room, holding at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_moves <= '0;
        end else if (w_move && (r_moves != {MOVE_W{1'b1}})) begin
            r_moves <= r_moves + MOVE_W'(1);
        end
    end

    // Moore outputs decoded from the current room only.
    always_comb begin
        room    = 7'd1 << r_state;
        room_id = r_state;
        sw      = (r_state == STASH);
        win     = (r_state == VAULT);
        die     = (r_state == GRAVE);
        moves   = r_moves;
    end

endmodule

// File: tb/tb_adventure_rooms.sv
// Directed bench for adventure_rooms: walks the map, checks Den outcomes,
// press filtering, and counter saturation on a narrow-counter instance.
module tb_adventure_rooms;
    import adv_pkg::*;

    logic       clk;
    logic       reset;
    logic [3:0] btn;
    logic       v;

    logic       sw,  sw2;
    logic [6:0] room, room2;
    logic [2:0] room_id, room_id2;
    logic       win, win2;
    logic       die, die2;
    logic [7:0] moves;
    logic [1:0] moves2;

    int errors;
    int checks;

    adventure_rooms #(.MOVE_W(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .btn_n   (btn[DIR_N]),
        .btn_s   (btn[DIR_S]),
        .btn_e   (btn[DIR_E]),
        .btn_w   (btn[DIR_W]),
        .v       (v),
        .sw      (sw),
        .room    (room),
        .room_id (room_id),
        .win     (win),
        .die     (die),
        .moves   (moves)
    );

    adventure_rooms #(.MOVE_W(2)) dut2 (
        .clk     (clk),
        .reset   (reset),
        .btn_n   (btn[DIR_N]),
        .btn_s   (btn[DIR_S]),
        .btn_e   (btn[DIR_E]),
        .btn_w   (btn[DIR_W]),
        .v       (v),
        .sw      (sw2),
        .room    (room2),
        .room_id (room_id2),
        .win     (win2),
        .die     (die2),
        .moves   (moves2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyReset();
        btn   = 4'b0000;
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic applyStimulus(input int dir);
        @(negedge clk);
        btn      = 4'b0000;
        btn[dir] = 1'b1;
        @(negedge clk);
        btn = 4'b0000;
        @(negedge clk);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        v      = 1'b0;
        btn    = 4'b0000;
        reset  = 1'b0;

        // 1: button held through reset release is not a press
        btn[DIR_E] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_room",    32'(room),    32'h01);
        checkOutput("rst_room_id", 32'(room_id), 32'd0);
        checkOutput("rst_moves",   32'(moves),   32'd0);
        checkOutput("rst_flags",   32'({sw, win, die}), 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("held_room",  32'(room),  32'h01);
        checkOutput("held_moves", 32'(moves), 32'd0);
        btn = 4'b0000;
        @(negedge clk);
        applyStimulus(DIR_E);
        checkOutput("t1_room",  32'(room),  32'h02);
        checkOutput("t1_moves", 32'(moves), 32'd1);

        // 2: visit the stash, then win
        applyReset();
        applyStimulus(DIR_E);
        applyStimulus(DIR_S);
        applyStimulus(DIR_N);
        checkOutput("stash_id", 32'(room_id), 32'd3);
        checkOutput("stash_sw", 32'(sw),      32'd1);
        applyStimulus(DIR_E);
        checkOutput("river_id",    32'(room_id), 32'd2);
        checkOutput("river_sw",    32'(sw),      32'd0);
        checkOutput("river_moves", 32'(moves),   32'd4);
        v = 1'b1;
        @(negedge clk);
        btn[DIR_E] = 1'b1;
        @(negedge clk);
        btn = 4'b0000;
        checkOutput("den_id",   32'(room_id), 32'd4);
        checkOutput("den_room", 32'(room),    32'h10);
        @(negedge clk);
        checkOutput("vault_id",    32'(room_id), 32'd5);
        checkOutput("vault_win",   32'(win),     32'd1);
        checkOutput("vault_moves", 32'(moves),   32'd5);

        // 3: no sword, die; terminal room ignores buttons
        v = 1'b0;
        applyReset();
        applyStimulus(DIR_E);
        applyStimulus(DIR_S);
        applyStimulus(DIR_E);
        checkOutput("grave_die", 32'(die),     32'd1);
        checkOutput("grave_win", 32'(win),     32'd0);
        checkOutput("grave_id",  32'(room_id), 32'd6);
        applyStimulus(DIR_N);
        applyStimulus(DIR_S);
        applyStimulus(DIR_E);
        applyStimulus(DIR_W);
        checkOutput("grave_hold_id",    32'(room_id), 32'd6);
        checkOutput("grave_hold_moves", 32'(moves),   32'd3);

        // 4: simultaneous presses are ignored
        applyReset();
        applyStimulus(DIR_E);
        @(negedge clk);
        btn[DIR_S] = 1'b1;
        btn[DIR_W] = 1'b1;
        @(negedge clk);
        btn = 4'b0000;
        @(negedge clk);
        checkOutput("dual_id",    32'(room_id), 32'd1);
        checkOutput("dual_moves", 32'(moves),   32'd1);
        applyStimulus(DIR_S);
        checkOutput("after_dual_id", 32'(room_id), 32'd2);

        // 5: invalid directions do not count; long hold is one move
        applyReset();
        applyStimulus(DIR_N);
        applyStimulus(DIR_S);
        applyStimulus(DIR_W);
        checkOutput("inval_id",    32'(room_id), 32'd0);
        checkOutput("inval_moves", 32'(moves),   32'd0);
        @(negedge clk);
        btn[DIR_E] = 1'b1;
        repeat (10) @(negedge clk);
        btn = 4'b0000;
        @(negedge clk);
        checkOutput("hold_id",    32'(room_id), 32'd1);
        checkOutput("hold_moves", 32'(moves),   32'd1);

        // 6: saturation on the 2-bit counter, then asynchronous reset
        applyReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(DIR_E);
            applyStimulus(DIR_W);
        end
        checkOutput("sat_wide",   32'(moves),    32'd10);
        checkOutput("sat_narrow", 32'(moves2),   32'd3);
        checkOutput("sat_id",     32'(room_id2), 32'd0);
        applyStimulus(DIR_E);
        checkOutput("sat_hold",   32'(moves2),   32'd3);
        checkOutput("sat_tunnel", 32'(room2),    32'h02);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_room",   32'(room),   32'h01);
        checkOutput("async_moves",  32'(moves),  32'd0);
        checkOutput("async_moves2", 32'(moves2), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
